mostra_campos: RTL

Parametrised successor to the fixed three-field entry display of the Sudoku HEX bank. Drives NUM_CAMPOS label/value digit pairs on 7-segment displays and shows each field's committed register value. The field currently being edited shows the live switch value and blinks. An error pulse flashes all value digits. It sits between the game FSM (estadoJogo, registers, erro) and the HEX outputs of the top level.

---
 rtl/mostra_campos.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mostra_campos.sv
// mostra_campos: label/value 7-segment display for NUM_CAMPOS entry fields.
// Each field shows a fixed label digit and its committed register value. The
// field being edited shows the live switch value and blinks, and an error
// pulse lights every segment of all value digits for a fixed time.
module mostra_campos #(
    parameter int                                   NUM_CAMPOS    = 3,
    parameter int                                   LARG_SWITCH   = 9,
    parameter int                                   LARG_ESTADO   = 3,
    parameter logic [NUM_CAMPOS*LARG_ESTADO-1:0]    ESTADOS_CAMPO = {3'b011, 3'b001, 3'b000},
    parameter logic [NUM_CAMPOS*4-1:0]              ROTULOS       = {4'hc, 4'hb, 4'ha},
    parameter int                                   PISCA_DIV     = 25_000_000,
    parameter int                                   ERRO_CICLOS   = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [LARG_SWITCH-1:0]      switch,
    input  logic [NUM_CAMPOS*4-1:0]     regs,
    input  logic [LARG_ESTADO-1:0]      estadoJogo,
    input  logic                        erro,
    output logic [NUM_CAMPOS*16-1:0]    hex_out,
    output logic [NUM_CAMPOS-1:0]       campo_ativo,
    output logic                        switch_valido
);

    localparam int PISCA_W = (PISCA_DIV > 1) ? $clog2(PISCA_DIV) : 1;
    localparam int ERRO_W  = $clog2(ERRO_CICLOS + 1);

    logic [3:0]                 sw_cod_reg;
    logic [3:0]                 sw_cod_next;
    logic                       sw_valido_next;
    logic [NUM_CAMPOS-1:0]      ativo_next;
    logic [LARG_ESTADO-1:0]     estado_reg;
    logic [PISCA_W-1:0]         pisca_cnt_reg;
    logic                       pisca_reg;
    logic [ERRO_W-1:0]          erro_cnt_reg;
    logic [NUM_CAMPOS*16-1:0]   hex_next;

    // One-hot switch encoder: bit k set alone gives code k+1, anything else gives 0.
    always_comb begin
        sw_cod_next    = 4'd0;
        sw_valido_next = 1'b0;
        if ((switch != '0) && ((switch & (switch - LARG_SWITCH'(1))) == '0)) begin
            sw_valido_next = 1'b1;
            for (int k = 0; k < LARG_SWITCH; k++) begin
                if (switch[k]) begin
                    sw_cod_next = 4'(k + 1);
                end
            end
        end
    end

    // Register the encoded switch value and its validity flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_cod_reg    <= 4'd0;
            switch_valido <= 1'b0;
        end else begin
            sw_cod_reg    <= sw_cod_next;
            switch_valido <= sw_valido_next;
        end
    end

    // Active-field match; scanning downward lets the lowest index win on overlap.
    always_comb begin
        ativo_next = '0;
        for (int i = NUM_CAMPOS - 1; i >= 0; i--) begin
            if (estadoJogo == ESTADOS_CAMPO[i*LARG_ESTADO +: LARG_ESTADO]) begin
                ativo_next    = '0;
                ativo_next[i] = 1'b1;
            end
        end
    end

    // Register the active-field flags for the outside world.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            campo_ativo <= '0;
        end else begin
            campo_ativo <= ativo_next;
        end
    end

    // Blink generator; a state change restarts it in the visible phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_reg    <= '0;
            pisca_cnt_reg <= '0;
            pisca_reg     <= 1'b1;
        end else begin
            estado_reg <= estadoJogo;
            if (estadoJogo != estado_reg) begin
                pisca_cnt_reg <= '0;
                pisca_reg     <= 1'b1;
            end else if (pisca_cnt_reg == PISCA_W'(PISCA_DIV - 1)) begin
                pisca_cnt_reg <= '0;
                pisca_reg     <= ~pisca_reg;
            end else begin
                pisca_cnt_reg <= pisca_cnt_reg + PISCA_W'(1);
            end
        end
    end

    // Error flash timer; a new pulse always reloads the full length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            erro_cnt_reg <= '0;
        end else if (erro) begin
            erro_cnt_reg <= ERRO_W'(ERRO_CICLOS);
        end else if (erro_cnt_reg != '0) begin
            erro_cnt_reg <= erro_cnt_reg - ERRO_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CAMPOS; gi++) begin : g_campo
            logic [7:0] rot_seg;
            logic [7:0] val_seg;
            logic [3:0] val_dig;
            logic [7:0] val_byte;

            SEG7_LUT u_rot (
                .dig (ROTULOS[4*gi +: 4]),
                .seg (rot_seg)
            );

            // The value digit is the live switch while editing, else the register.
            assign val_dig = ativo_next[gi] ? sw_cod_reg : regs[4*gi +: 4];

            SEG7_LUT u_val (
                .dig (val_dig),
                .seg (val_seg)
            );

            // Value byte priority: error flash, blink-off, live switch, register.
            always_comb begin
                val_byte = 8'hFF;
                if (erro_cnt_reg != '0) begin
                    val_byte = 8'h00;
                end else if (ativo_next[gi]) begin
                    if (pisca_reg && switch_valido) begin
                        val_byte = val_seg;
                    end
                end else if (val_dig != 4'd0) begin
                    val_byte = val_seg;
                end
            end

            // Field 0 is leftmost, so it occupies the most significant pair.
            assign hex_next[16*(NUM_CAMPOS-gi)-1 -: 16] = {rot_seg, val_byte};
        end
    endgenerate

    // Output register for every display byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_out <= '1;
        end else begin
            hex_out <= hex_next;
        end
    end

endmodule

// SEG7_LUT: hex digit to active-low segment byte, decimal point kept dark.
module SEG7_LUT (
    input  logic [3:0] dig,
    output logic [7:0] seg
);

    // Plain lookup, bit 7 is the decimal point and stays off.
    always_comb begin
        seg = 8'hFF;
        case (dig)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h98;
            4'ha: seg = 8'h88;
            4'hb: seg = 8'h83;
            4'hc: seg = 8'hC6;
            4'hd: seg = 8'hA1;
            4'he: seg = 8'h86;
            4'hf: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule
